stall_ctrl: RTL
===============

# stall_ctrl

Hazard and stall controller for the five-stage pipeline. It classifies the instructions in D, E and M. From that it drives the fetch/decode enables (PC and IF/ID pipeline register) and the ID/EX bubble clear. It also tracks occupancy of the multi-cycle mult/div unit with an internal busy counter. It sits beside the datapath and replaces ad-hoc stall wiring; forwarding muxes stay elsewhere and are assumed complete for every non-stalled case.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles following a mult/multu in E
- DIV_CYC, 10, busy cycles following a div/divu in E

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- D_IR  input  32  instruction in decode (IF/ID output)
- E_IR  input  32  instruction in execute
- M_IR  input  32  instruction in memory stage
- PC_En  output  1  PC write enable; 0 = hold
- D_En  output  1  IF/ID enable; 0 = hold
- E_Clr  output  1  1 = load ID/EX with nop (32'h0) this edge
- MD_Busy  output  1  mult/div unit occupied (started in E now or counter nonzero)

## Operation
- Supported set: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo, nop. Any unlisted encoding is treated as nop (no source, no destination).
- Destination: rd for R-type writers (addu, subu, mfhi, mflo); rt for ori, lui, lw; 31 for jal. A destination of 0 never causes a hazard.
- Tuse (cycles from D until a value is needed):
  - rs: beq/jr → 0; addu, subu, ori, lw, sw, mult*, div*, mthi, mtlo → 1.
  - rt: beq → 0; addu, subu, mult*, div* → 1; sw → 2.
- Tnew (cycles until the result is available):
  - In E: lw → 2; addu, subu, ori, lui, mfhi, mflo → 1; jal → 0.
  - In M: lw → 1; all others → 0.
- Data stall: for each used source with register ≠ 0:
  - stall if it matches the E destination and Tuse < Tnew_E, or
  - stall if it matches the M destination and Tuse < Tnew_M.
- MD stall: D is any of mult*, div*, mfhi, mflo, mthi, mtlo, and MD_Busy = 1.
- stall = data stall OR MD stall. Then PC_En = D_En = ~stall and E_Clr = stall.
- Busy counter cnt (4 bits):
  - E_IR is mult/multu → cnt ← MULT_CYC.
  - E_IR is div/divu → cnt ← DIV_CYC.
  - Otherwise, if cnt ≠ 0, cnt ← cnt−1.
- Start in E while cnt ≠ 0 cannot occur legally (the MD stall prevents it); if it does, the reload wins.
- MD_Busy = (E_IR is mult*/div*) | (cnt ≠ 0).

## Timing
- All stall outputs are combinational from the IR inputs and cnt; there is zero latency from an IR change to the stall decision.
- Mult in E at cycle t: MD_Busy = 1 for cycles t … t+MULT_CYC; it is 0 at t+MULT_CYC+1.
  - Div: the same, with DIV_CYC.
- A stalled instruction is re-evaluated every cycle. The stall releases in the first cycle in which the condition is false; there is no extra dead cycle.
- Reset (synchronous): cnt ← 0 and the perf counter ← 0. Reset mid-busy aborts occupancy, so MD_Busy = 0 in the cycle after reset unless E_IR is itself a start.
- Output values while reset is asserted follow the combinational rules with cnt treated as 0. With nop IRs this gives PC_En = 1, D_En = 1, E_Clr = 0, MD_Busy = 0.
- Simultaneous data and MD stall: a single stall is produced; the outputs are identical.

## Configuration
- STALL_CNT_EN defined:
  - Adds output Stall_Cnt [31:0], which increments on every clock edge where stall = 1 and reset = 0.
  - It wraps from 32'hFFFFFFFF to 0 and resets to 0.
- STALL_CNT_EN undefined: the port and the register are absent, and behaviour is otherwise identical.

## Structure
- Shared package holds:
  - opcode/funct constants;
  - Tuse/Tnew encodings (2-bit);
  - the nop constant 32'h0;
  - default MULT_CYC/DIV_CYC values.
- Sub-module instr_class: pure combinational decode of one IR into rs, rt, dst, Tuse_rs, Tuse_rt, Tnew, is_md_start, is_md_use. It is instantiated three times (D, E, M); the E and M Tnew values come from a stage input.
- The top level holds the compare logic, the busy counter and the optional perf counter.

## Test plan
- Load-use: E = lw $8 and D = addu $9,$8,$10 → one cycle with PC_En = 0, D_En = 0, E_Clr = 1. Next cycle (lw in M, Tnew 1 ≥ Tuse 1) → no stall.
- Branch dependency: E = addu $3 and D = beq $3,$0 → stall one cycle, then M = addu (Tnew 0) releases it. With E = lw $3 and D = beq $3 → 2 stall cycles.
- Store data: E = lw $5 and D = sw $5,0($6) → no stall (Tuse_rt 2 ≥ Tnew 2). Register $0 as destination/source → never stalls.
- Mult occupancy: mult in E at cycle t and mflo in D at t+1 → stall cycles t+1 … t+5 (MD_Busy 1), released at t+6. A div repeats this with release at t+11.
- Reset mid-busy: div in E, assert reset at t+3 → MD_Busy = 0 at t+4 and a mfhi in D proceeds immediately.
- With STALL_CNT_EN defined: the load-use plus mult sequence above gives Stall_Cnt = 6. Preloading via 2^32−1 forced stalls in a reduced run shows the wrap to 0.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// rtl/stall_ctrl_pkg.sv - shared opcodes, Tuse/Tnew encodings and stall helpers
// Imported by instr_class and stall_ctrl.
package stall_ctrl_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int MULT_CYC_DEFAULT = 5;
  localparam int DIV_CYC_DEFAULT  = 10;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // TUSE_NONE is larger than any Tnew, so an unused source can never stall.
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  typedef enum logic [1:0] {
    STAGE_D = 2'd0,
    STAGE_E = 2'd1,
    STAGE_M = 2'd2
  } stage_e;

  function automatic logic raw_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] dst, input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/stall_ctrl_instr_class.sv
// rtl/stall_ctrl_instr_class.sv - combinational classification of one instruction
// Unlisted encodings decode as nop: no sources, no destination.
module instr_class
  import stall_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  input  stage_e      stage,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dst,
  output logic [1:0]  tuse_rs,
  output logic [1:0]  tuse_rt,
  output logic [1:0]  tnew,
  output logic        is_md_start,
  output logic        is_md_use
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rd;
  logic [1:0] tnew_e;
  logic       is_load;
  logic       unused_shamt;

  assign op           = ir[31:26];
  assign funct        = ir[5:0];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign unused_shamt = ^ir[10:6];

  always_comb begin
    dst         = 5'd0;
    tuse_rs     = TUSE_NONE;
    tuse_rt     = TUSE_NONE;
    tnew_e      = TNEW_0;
    is_load     = 1'b0;
    is_md_start = 1'b0;
    is_md_use   = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU, FN_SUBU: begin
            dst     = rd;
            tuse_rs = TUSE_1;
            tuse_rt = TUSE_1;
            tnew_e  = TNEW_1;
          end
          FN_JR: tuse_rs = TUSE_0;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            tuse_rs     = TUSE_1;
            tuse_rt     = TUSE_1;
            is_md_start = 1'b1;
            is_md_use   = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            dst       = rd;
            tnew_e    = TNEW_1;
            is_md_use = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            tuse_rs   = TUSE_1;
            is_md_use = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        dst     = rt;
        tuse_rs = TUSE_1;
        tnew_e  = TNEW_1;
      end
      OP_LUI: begin
        dst    = rt;
        tnew_e = TNEW_1;
      end
      OP_LW: begin
        dst     = rt;
        tuse_rs = TUSE_1;
        tnew_e  = TNEW_2;
        is_load = 1'b1;
      end
      OP_SW: begin
        tuse_rs = TUSE_1;
        tuse_rt = TUSE_2;
      end
      OP_BEQ: begin
        tuse_rs = TUSE_0;
        tuse_rt = TUSE_0;
      end
      OP_JAL: dst = 5'd31;
      default: ;
    endcase
  end

  // Only a load is still in flight once it reaches M.
  always_comb begin
    case (stage)
      STAGE_M: tnew = is_load ? TNEW_1 : TNEW_0;
      default: tnew = tnew_e;
    endcase
  end

endmodule

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline hazard/stall controller with mult/div busy tracking
// Define STALL_CNT_EN to add the Stall_Cnt performance counter output.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEFAULT,
  parameter int DIV_CYC  = DIV_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D_IR,
  input  logic [31:0] E_IR,
  input  logic [31:0] M_IR,
  output logic        PC_En,
  output logic        D_En,
  output logic        E_Clr,
  output logic        MD_Busy
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] Stall_Cnt
`endif
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

  logic [4:0] d_rs, d_rt, e_dst, m_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic       d_md_use, e_md_start;

  logic [4:0] d_dst_unused, e_rs_unused, e_rt_unused, m_rs_unused, m_rt_unused;
  logic [1:0] d_tnew_unused, e_tuse_rs_unused, e_tuse_rt_unused;
  logic [1:0] m_tuse_rs_unused, m_tuse_rt_unused;
  logic       d_md_start_unused, e_md_use_unused, m_md_start_unused, m_md_use_unused;

  instr_class u_d (
    .ir(D_IR), .stage(STAGE_D),
    .rs(d_rs), .rt(d_rt), .dst(d_dst_unused),
    .tuse_rs(d_tuse_rs), .tuse_rt(d_tuse_rt), .tnew(d_tnew_unused),
    .is_md_start(d_md_start_unused), .is_md_use(d_md_use)
  );

  instr_class u_e (
    .ir(E_IR), .stage(STAGE_E),
    .rs(e_rs_unused), .rt(e_rt_unused), .dst(e_dst),
    .tuse_rs(e_tuse_rs_unused), .tuse_rt(e_tuse_rt_unused), .tnew(e_tnew),
    .is_md_start(e_md_start), .is_md_use(e_md_use_unused)
  );

  instr_class u_m (
    .ir(M_IR), .stage(STAGE_M),
    .rs(m_rs_unused), .rt(m_rt_unused), .dst(m_dst),
    .tuse_rs(m_tuse_rs_unused), .tuse_rt(m_tuse_rt_unused), .tnew(m_tnew),
    .is_md_start(m_md_start_unused), .is_md_use(m_md_use_unused)
  );

  logic [3:0] cnt;
  logic [3:0] cnt_eff;
  logic       data_stall;
  logic       md_stall;
  logic       stall;

  // Outputs see an idle unit while reset is held, even mid-busy.
  assign cnt_eff = reset ? 4'd0 : cnt;
  assign MD_Busy = e_md_start | (cnt_eff != 4'd0);

  assign data_stall = raw_hazard(d_rs, d_tuse_rs, e_dst, e_tnew)
                    | raw_hazard(d_rs, d_tuse_rs, m_dst, m_tnew)
                    | raw_hazard(d_rt, d_tuse_rt, e_dst, e_tnew)
                    | raw_hazard(d_rt, d_tuse_rt, m_dst, m_tnew);
  assign md_stall   = d_md_use & MD_Busy;
  assign stall      = data_stall | md_stall;

  assign PC_En = ~stall;
  assign D_En  = ~stall;
  assign E_Clr = stall;

  // funct bit 1 separates div/divu from mult/multu.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (e_md_start) begin
      cnt <= E_IR[1] ? DIV_LOAD : MULT_LOAD;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
`endif

endmodule
